// File: rtl/filter_ctrl.sv
// rtl/filter_ctrl.sv - sample-period sequencer for a serial-multiply IIR stage.
// Staged coefficients and the input sample are latched only at LOAD so they stay stable while multiplying.
module filter_ctrl #(
  parameter int unsigned DIV         = 32,
  parameter int unsigned MULT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        din_valid,
  input  logic [15:0] din,
  output logic        din_ready,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  output logic [15:0] din_q,
  output logic [7:0]  coef_a,
  output logic [7:0]  coef_b,
  output logic        mult_rst,
  output logic        sample_stb,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [2:0] {IDLE, LOAD, MULT, COMMIT, WAIT} state_t;

  localparam logic [15:0] CNT_LAST  = 16'(DIV - 1);
  localparam logic [15:0] MULT_LAST = 16'(MULT_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] din_q_q, din_q_d;
  logic [7:0]  coef_a_q, coef_a_d, coef_b_q, coef_b_d;
  logic [7:0]  stg_a_q, stg_a_d, stg_b_q, stg_b_d;
  logic        pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic        underrun_q, underrun_d;
  logic        mult_rst_q, mult_rst_d;
  logic        sample_stb_q, sample_stb_d;
  logic        busy_q, busy_d;
  logic        load, und_set, und_clr;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    din_q_d  = din_q_q;
    coef_a_d = coef_a_q;
    coef_b_d = coef_b_q;
    stg_a_d  = stg_a_q;
    stg_b_d  = stg_b_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    und_set  = 1'b0;
    und_clr  = 1'b0;
    load     = (state_q == LOAD);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = 16'd1;
        state_d = (MULT_CYCLES == 0) ? COMMIT : MULT;
      end
      MULT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == MULT_LAST) state_d = COMMIT;
      end
      COMMIT, WAIT: begin
        // Minimum DIV lets COMMIT sit on the last count and go straight back to LOAD
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          state_d = WAIT;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    if (!en && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    if (load) begin
      if (din_valid) din_q_d = din;
      else           und_set = 1'b1;
      if (pend_a_q) begin
        coef_a_d = stg_a_q;
        pend_a_d = 1'b0;
      end
      if (pend_b_q) begin
        coef_b_d = stg_b_q;
        pend_b_d = 1'b0;
      end
    end

    // A write landing on LOAD re-arms pending after the copy above, so it waits one period
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: begin
          stg_a_d  = cfg_wdata;
          pend_a_d = 1'b1;
        end
        2'd1: begin
          stg_b_d  = cfg_wdata;
          pend_b_d = 1'b1;
        end
        2'd2:    und_clr = 1'b1;
        default: ;
      endcase
    end

    underrun_d   = und_set | (underrun_q & ~und_clr);
    mult_rst_d   = (state_d == IDLE) || (state_d == LOAD);
    sample_stb_d = (state_d == COMMIT);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      din_q_q      <= '0;
      coef_a_q     <= '0;
      coef_b_q     <= '0;
      stg_a_q      <= '0;
      stg_b_q      <= '0;
      pend_a_q     <= 1'b0;
      pend_b_q     <= 1'b0;
      underrun_q   <= 1'b0;
      mult_rst_q   <= 1'b1;
      sample_stb_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      din_q_q      <= din_q_d;
      coef_a_q     <= coef_a_d;
      coef_b_q     <= coef_b_d;
      stg_a_q      <= stg_a_d;
      stg_b_q      <= stg_b_d;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      underrun_q   <= underrun_d;
      mult_rst_q   <= mult_rst_d;
      sample_stb_q <= sample_stb_d;
      busy_q       <= busy_d;
    end
  end

  assign din_ready  = load & din_valid;
  assign din_q      = din_q_q;
  assign coef_a     = coef_a_q;
  assign coef_b     = coef_b_q;
  assign mult_rst   = mult_rst_q;
  assign sample_stb = sample_stb_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_filter_ctrl.sv
// tb/tb_filter_ctrl.sv - directed bench for filter_ctrl at DIV=32 and the minimum DIV=10.
module tb_filter_ctrl;
  localparam int DIV  = 32;
  localparam int MC   = 8;
  localparam int DIV2 = 10;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, din_valid = 1'b0, cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_wdata = '0;
  logic [15:0] din = '0;

  logic        din_ready, mult_rst, sample_stb, busy, underrun;
  logic [15:0] din_q;
  logic [7:0]  coef_a, coef_b;
  logic        din_ready2, mult_rst2, sample_stb2, busy2, underrun2;
  logic [15:0] din_q2;
  logic [7:0]  coef_a2, coef_b2;

  always #5 clk = ~clk;

  filter_ctrl #(.DIV(DIV), .MULT_CYCLES(MC)) u_dut (
    .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .din_q(din_q),
    .coef_a(coef_a), .coef_b(coef_b), .mult_rst(mult_rst), .sample_stb(sample_stb),
    .busy(busy), .underrun(underrun)
  );

  filter_ctrl #(.DIV(DIV2), .MULT_CYCLES(MC)) u_dut_min (
    .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din), .din_ready(din_ready2),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .din_q(din_q2),
    .coef_a(coef_a2), .coef_b(coef_b2), .mult_rst(mult_rst2), .sample_stb(sample_stb2),
    .busy(busy2), .underrun(underrun2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase within the period, staged/active coefficients, sticky underrun
  bit          m_busy = 1'b0;
  int          ph = 0;
  int          ph2 = 0;
  logic [15:0] mdin = '0;
  logic [7:0]  ca = '0, cb = '0, sa = '0, sb = '0;
  bit          pa = 1'b0, pb = 1'b0, mund = 1'b0;
  logic [15:0] sbq[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic advance();
    bit ld;
    bit clr;
    if (rst) begin
      m_busy = 1'b0; ph = 0; ph2 = 0; mdin = '0;
      ca = '0; cb = '0; sa = '0; sb = '0; pa = 1'b0; pb = 1'b0; mund = 1'b0;
      sbq.delete();
      return;
    end
    ld  = m_busy && ph == 0;
    clr = cfg_we && cfg_addr == 2'd2;
    if (ld) begin
      if (din_valid) mdin = din;
      if (pa) begin ca = sa; pa = 1'b0; end
      if (pb) begin cb = sb; pb = 1'b0; end
      mund = !din_valid ? 1'b1 : (clr ? 1'b0 : mund);
      sbq.push_back(mdin);
    end else if (clr) begin
      mund = 1'b0;
    end
    if (cfg_we && cfg_addr == 2'd0) begin sa = cfg_wdata; pa = 1'b1; end
    if (cfg_we && cfg_addr == 2'd1) begin sb = cfg_wdata; pb = 1'b1; end
    if (!m_busy) begin
      if (en) begin m_busy = 1'b1; ph = 0; ph2 = 0; end
    end else if (!en) begin
      m_busy = 1'b0;
      sbq.delete();
    end else begin
      ph  = (ph + 1) % DIV;
      ph2 = (ph2 + 1) % DIV2;
    end
  endtask

  task automatic compare();
    chk("busy",       16'(busy),       16'(m_busy));
    chk("mult_rst",   16'(mult_rst),   16'(!m_busy || ph == 0));
    chk("sample_stb", 16'(sample_stb), 16'(m_busy && ph == MC + 1));
    chk("din_ready",  16'(din_ready),  16'(m_busy && ph == 0 && din_valid));
    chk("din_q",      din_q,           mdin);
    chk("coef_a",     16'(coef_a),     16'(ca));
    chk("coef_b",     16'(coef_b),     16'(cb));
    chk("underrun",   16'(underrun),   16'(mund));
    chk("min_busy",       16'(busy2),       16'(m_busy));
    chk("min_mult_rst",   16'(mult_rst2),   16'(!m_busy || ph2 == 0));
    chk("min_sample_stb", 16'(sample_stb2), 16'(m_busy && ph2 == MC + 1));
    chk("min_din_ready",  16'(din_ready2),  16'(m_busy && ph2 == 0 && din_valid));
    if (sample_stb) begin
      chk("sb_nonempty", 16'(sbq.size() > 0), 16'd1);
      if (sbq.size() > 0) chk("sb_din_q", din_q, sbq.pop_front());
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      advance();
      #1 din = 16'($urandom);
      #1 compare();
    end
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < 2 * DIV + 4; i++) begin
      if (m_busy && ph == p) break;
      cyc(1);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    // Reset must dominate en and cfg_we
    rst = 1'b1; en = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'h55;
    cyc(2);
    cfg_we = 1'b0; en = 1'b0;
    cyc(1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_mult_rst", 16'(mult_rst), 16'd1);
    rst = 1'b0;
    cyc(2);

    en = 1'b1; din_valid = 1'b1;
    cyc(100);

    wait_ph(20);
    cfg_write(2'd0, 8'hE0);
    wait_ph(0);
    chk("coef_a_before_load", 16'(coef_a), 16'h00);
    cyc(1);
    chk("coef_a_after_load", 16'(coef_a), 16'hE0);

    wait_ph(0);
    cfg_write(2'd1, 8'h3C);
    chk("coef_b_same_load", 16'(coef_b), 16'h00);
    wait_ph(0);
    cyc(1);
    chk("coef_b_next_load", 16'(coef_b), 16'h3C);

    wait_ph(15);
    cfg_write(2'd0, 8'h11);
    cfg_write(2'd0, 8'h22);
    wait_ph(1);
    chk("coef_a_last_wins", 16'(coef_a), 16'h22);

    wait_ph(10);
    din_valid = 1'b0;
    wait_ph(1);
    din_valid = 1'b1;
    chk("underrun_set", 16'(underrun), 16'd1);
    cyc(40);
    chk("underrun_held", 16'(underrun), 16'd1);
    cfg_write(2'd2, 8'h00);
    chk("underrun_clr", 16'(underrun), 16'd0);

    wait_ph(0);
    din_valid = 1'b0;
    cfg_write(2'd2, 8'h00);
    din_valid = 1'b1;
    chk("underrun_set_wins", 16'(underrun), 16'd1);
    cfg_write(2'd2, 8'h00);
    cfg_write(2'd3, 8'hFF);

    wait_ph(5);
    en = 1'b0;
    cyc(1);
    chk("abort_busy", 16'(busy), 16'd0);
    cyc(20);
    en = 1'b1;
    cyc(1);
    chk("restart_load", 16'(mult_rst & busy), 16'd1);
    cyc(9);
    chk("restart_stb", 16'(sample_stb), 16'd1);

    wait_ph(9);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_commit_coef_a", 16'(coef_a), 16'h00);
    chk("rst_commit_coef_b", 16'(coef_b), 16'h00);
    chk("rst_commit_stb", 16'(sample_stb), 16'd0);
    chk("rst_commit_din_q", din_q, 16'h0000);
    cyc(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
